// File: rtl/out_read_scheduler.sv
// Per-output round-robin read scheduler for the shared-memory switch.
// One lane per output port picks a non-empty input queue and reads it in bounded bursts.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module out_read_lane #(
  parameter int PORT_NUB   = 4,
  parameter int WIDTH_SEL  = 2,
  parameter int MAX_BURST  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sched_en,
  input  logic                 tx_ready,
  input  logic [PORT_NUB-1:0]  empty,
  output logic [WIDTH_SEL-1:0] rd_sel,
  output logic                 rd_en,
  output logic                 out_valid,
  output logic [WIDTH_SEL-1:0] out_src,
  output logic                 busy
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                 state, state_n;
  logic [WIDTH_SEL-1:0]   ptr, ptr_n, cur, cur_n, winner, idx;
  logic [CW-1:0]          cnt, cnt_n;
  logic                   any_req;
  logic [RD_LATENCY:1]    vld_pipe;
  logic [RD_LATENCY:1][WIDTH_SEL-1:0] src_pipe;

  // Scan from ptr down to ptr+1 so the closest non-empty queue after ptr wins last.
  always_comb begin
    winner = ptr;
    idx    = '0;
    for (int k = PORT_NUB; k >= 1; k--) begin
      idx = WIDTH_SEL'((int'(ptr) + k) % PORT_NUB);
      if (!empty[idx]) winner = idx;
    end
  end

  assign any_req = |(~empty);
  assign rd_en   = (state == BURST) && sched_en && tx_ready && !empty[cur];
  assign rd_sel  = cur;
  assign busy    = (state == BURST);

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cur_n   = cur;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (sched_en && any_req) begin
          cur_n   = winner;
          cnt_n   = '0;
          state_n = BURST;
        end
      end
      BURST: begin
        if (!sched_en || empty[cur]) begin
          state_n = IDLE;
          ptr_n   = cur;
        end else if (!tx_ready) begin
          state_n = BURST;
        end else if (cnt == CW'(MAX_BURST - 1)) begin
          state_n = IDLE;
          ptr_n   = cur;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= WIDTH_SEL'(PORT_NUB - 1);
      cur   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cur   <= cur_n;
      cnt   <= cnt_n;
    end
  end

  // Tag pipeline tracks the memory read latency; only reset flushes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      src_pipe <= '0;
    end else begin
      for (int s = RD_LATENCY; s >= 2; s--) begin
        vld_pipe[s] <= vld_pipe[s-1];
        src_pipe[s] <= src_pipe[s-1];
      end
      vld_pipe[1] <= rd_en;
      src_pipe[1] <= rd_en ? cur : '0;
    end
  end

  assign out_valid = vld_pipe[RD_LATENCY];
  assign out_src   = src_pipe[RD_LATENCY];
endmodule

module out_read_scheduler #(
  parameter int PORT_NUB   = `PORT_NUB_TOTAL,
  parameter int WIDTH_SEL  = $clog2(PORT_NUB),
  parameter int MAX_BURST  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sched_en,
  input  logic [PORT_NUB*PORT_NUB-1:0]  empty,
  input  logic [PORT_NUB-1:0]           tx_ready,
  output logic [WIDTH_SEL*PORT_NUB-1:0] rd_sel,
  output logic [PORT_NUB-1:0]           rd_en,
  output logic [PORT_NUB-1:0]           out_valid,
  output logic [WIDTH_SEL*PORT_NUB-1:0] out_src,
  output logic [PORT_NUB-1:0]           busy
);
  for (genvar i = 0; i < PORT_NUB; i++) begin : g_lane
    out_read_lane #(
      .PORT_NUB   (PORT_NUB),
      .WIDTH_SEL  (WIDTH_SEL),
      .MAX_BURST  (MAX_BURST),
      .RD_LATENCY (RD_LATENCY)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .sched_en  (sched_en),
      .tx_ready  (tx_ready[i]),
      .empty     (empty[i*PORT_NUB +: PORT_NUB]),
      .rd_sel    (rd_sel[i*WIDTH_SEL +: WIDTH_SEL]),
      .rd_en     (rd_en[i]),
      .out_valid (out_valid[i]),
      .out_src   (out_src[i*WIDTH_SEL +: WIDTH_SEL]),
      .busy      (busy[i])
    );
  end
endmodule

// File: tb/tb_out_read_scheduler.sv
// Bench for out_read_scheduler: queue-occupancy environment, cycle reference model, directed scenarios.
module tb_out_read_scheduler;
  localparam int P  = 4;
  localparam int WS = 2;
  localparam int MB = 4;
  localparam int RL = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sched_en = 1'b0;
  logic [P*P-1:0]  empty = '1;
  logic [P-1:0]    tx_ready = '0;
  logic [WS*P-1:0] rd_sel;
  logic [P-1:0]    rd_en;
  logic [P-1:0]    out_valid;
  logic [WS*P-1:0] out_src;
  logic [P-1:0]    busy;

  out_read_scheduler #(.PORT_NUB(P), .WIDTH_SEL(WS), .MAX_BURST(MB), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en), .empty(empty), .tx_ready(tx_ready),
    .rd_sel(rd_sel), .rd_en(rd_en), .out_valid(out_valid), .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int qcnt [P][P];
  // Reference model: bursting flag, granted queue, reads so far, last served queue.
  logic [P-1:0] m_act;
  int m_sel [P], m_cnt [P], m_ptr [P];
  logic [P-1:0] hv [RL];
  int hs [RL][P];
  logic chk_en = 1'b0;
  logic [P-1:0] o_rd, o_busy, o_ov;
  int o_sel [P], o_src [P];

  task automatic drive_empty();
    for (int i = 0; i < P; i++)
      for (int j = 0; j < P; j++)
        empty[i*P+j] = (qcnt[i][j] == 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      m_act[i] = 1'b0; m_sel[i] = 0; m_cnt[i] = 0; m_ptr[i] = P-1;
    end
    for (int k = 0; k < RL; k++) begin
      hv[k] = '0;
      for (int i = 0; i < P; i++) hs[k][i] = 0;
    end
  endtask

  task automatic step();
    logic [P-1:0] erd;
    int rsel [P];
    int w;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < P; i++) begin
      o_rd[i] = rd_en[i]; o_busy[i] = busy[i]; o_ov[i] = out_valid[i];
      o_sel[i] = int'(rd_sel[i*WS +: WS]); o_src[i] = int'(out_src[i*WS +: WS]);
      erd[i] = m_act[i] && sched_en && tx_ready[i] && (qcnt[i][m_sel[i]] > 0);
      rsel[i] = m_sel[i];
    end
    if (chk_en) begin
      for (int i = 0; i < P; i++) begin
        checks++;
        if (o_rd[i] !== erd[i]) begin errors++;
          $display("FAIL model_rd_en[%0d] cyc %0d got %0b exp %0b", i, cyc, o_rd[i], erd[i]); end
        checks++;
        if (o_sel[i] != m_sel[i]) begin errors++;
          $display("FAIL model_rd_sel[%0d] cyc %0d got %0d exp %0d", i, cyc, o_sel[i], m_sel[i]); end
        checks++;
        if (o_busy[i] !== m_act[i]) begin errors++;
          $display("FAIL model_busy[%0d] cyc %0d got %0b exp %0b", i, cyc, o_busy[i], m_act[i]); end
        checks++;
        if (o_ov[i] !== hv[RL-1][i]) begin errors++;
          $display("FAIL model_out_valid[%0d] cyc %0d got %0b exp %0b", i, cyc, o_ov[i], hv[RL-1][i]); end
        if (hv[RL-1][i]) begin
          checks++;
          if (o_src[i] != hs[RL-1][i]) begin errors++;
            $display("FAIL model_out_src[%0d] cyc %0d got %0d exp %0d", i, cyc, o_src[i], hs[RL-1][i]); end
        end
      end
    end
    if (rst) model_reset();
    else begin
      for (int k = RL-1; k >= 1; k--) begin hv[k] = hv[k-1]; hs[k] = hs[k-1]; end
      hv[0] = erd;
      for (int i = 0; i < P; i++) hs[0][i] = erd[i] ? m_sel[i] : 0;
      for (int i = 0; i < P; i++) begin
        if (!m_act[i]) begin
          w = -1;
          if (sched_en)
            for (int k = 1; k <= P; k++)
              if (w < 0 && qcnt[i][(m_ptr[i]+k)%P] > 0) w = (m_ptr[i]+k)%P;
          if (w >= 0) begin m_act[i] = 1'b1; m_sel[i] = w; m_cnt[i] = 0; end
        end else if (!sched_en || qcnt[i][m_sel[i]] == 0) begin
          m_act[i] = 1'b0; m_ptr[i] = m_sel[i];
        end else if (tx_ready[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == MB) begin m_act[i] = 1'b0; m_ptr[i] = m_sel[i]; end
        end
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < P; i++) if (erd[i]) qcnt[i][rsel[i]]--;
    drive_empty();
  endtask

  task automatic do_reset();
    for (int i = 0; i < P; i++) for (int j = 0; j < P; j++) qcnt[i][j] = 0;
    drive_empty();
    rst = 1'b1; step(); rst = 1'b0;
    sched_en = 1'b1; tx_ready = '1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sched_en = 1'b1;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < P; i++) for (int j = 0; j < P; j++) qcnt[i][j] = $urandom_range(0, 2);
      tx_ready = P'($urandom);
      drive_empty();
      step();
      chk_en = 1'b1;
      if (n > 0) begin
        checks++;
        if (o_rd !== '0 || o_busy !== '0 || o_ov !== '0) begin errors++;
          $display("FAIL reset_outputs n %0d rd_en %b busy %b out_valid %b exp 0", n, o_rd, o_busy, o_ov); end
        for (int i = 0; i < P; i++) begin
          checks++;
          if (o_sel[i] != 0 || o_src[i] != 0) begin errors++;
            $display("FAIL reset_sel_src[%0d] got %0d/%0d exp 0/0", i, o_sel[i], o_src[i]); end
        end
      end
    end
    for (int i = 0; i < P; i++) for (int j = 0; j < P; j++) qcnt[i][j] = 0;
    drive_empty();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (o_rd !== '0) begin errors++; $display("FAIL reset_idle_rd_en got %b exp 0", o_rd); end
    end
  endtask

  task automatic test_single_queue();
    logic [6:0] rdv, bv, ovv;
    do_reset();
    qcnt[1][2] = 3; drive_empty();
    for (int k = 0; k < 7; k++) begin
      step();
      rdv[k] = o_rd[1]; bv[k] = o_busy[1]; ovv[k] = o_ov[1];
      if (o_rd[1]) begin checks++;
        if (o_sel[1] != 2) begin errors++; $display("FAIL single_rd_sel got %0d exp 2", o_sel[1]); end end
      if (o_ov[1]) begin checks++;
        if (o_src[1] != 2) begin errors++; $display("FAIL single_out_src got %0d exp 2", o_src[1]); end end
    end
    checks++;
    if (rdv !== 7'b0001110) begin errors++; $display("FAIL single_rd_en_seq got %b exp 0001110", rdv); end
    checks++;
    if (bv !== 7'b0011110) begin errors++; $display("FAIL single_busy_seq got %b exp 0011110", bv); end
    checks++;
    if (ovv !== 7'b0011100) begin errors++; $display("FAIL single_out_valid_seq got %b exp 0011100", ovv); end
  endtask

  task automatic test_round_robin();
    int rs[$], rl[$];
    int exp_s [9] = '{0, 1, 3, 0, 1, 3, 0, 1, 3};
    int exp_l [9] = '{4, 4, 4, 4, 4, 4, 2, 2, 2};
    int gap = 0, prev_sel = -1, bad2 = 0;
    logic prev_rd = 1'b0;
    do_reset();
    qcnt[1][0] = 10; qcnt[1][1] = 10; qcnt[1][3] = 10; drive_empty();
    for (int k = 0; k < 60; k++) begin
      step();
      if (o_rd[1]) begin
        if (o_sel[1] == 2) bad2++;
        if (!prev_rd || o_sel[1] != prev_sel) begin
          if (rs.size() > 0) begin checks++;
            if (gap != 1) begin errors++; $display("FAIL rr_idle_gap run %0d got %0d exp 1", rs.size(), gap); end
          end
          rs.push_back(o_sel[1]); rl.push_back(1); gap = 0;
        end else rl[rl.size()-1]++;
      end else if (!o_busy[1] && rs.size() > 0) gap++;
      prev_rd = o_rd[1]; prev_sel = o_sel[1];
    end
    checks++;
    if (bad2 != 0) begin errors++; $display("FAIL rr_queue2_selected got %0d exp 0", bad2); end
    checks++;
    if (rs.size() != 9) begin errors++; $display("FAIL rr_num_bursts got %0d exp 9", rs.size()); end
    else for (int r = 0; r < 9; r++) begin
      checks++;
      if (rs[r] != exp_s[r] || rl[r] != exp_l[r]) begin errors++;
        $display("FAIL rr_burst %0d got q%0d(%0d) exp q%0d(%0d)", r, rs[r], rl[r], exp_s[r], exp_l[r]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    qcnt[1][2] = 8; drive_empty();
    step();
    for (int k = 0; k < 2; k++) begin
      step(); checks++;
      if (o_rd[1] !== 1'b1) begin errors++; $display("FAIL bp_pre_read %0d got %0b exp 1", k, o_rd[1]); end
    end
    tx_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); checks++;
      if (o_rd[1] !== 1'b0 || o_busy[1] !== 1'b1 || o_sel[1] != 2) begin errors++;
        $display("FAIL bp_stall %0d got rd %0b busy %0b sel %0d exp 0 1 2", k, o_rd[1], o_busy[1], o_sel[1]); end
    end
    tx_ready[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(); checks++;
      if (o_rd[1] !== 1'b1 || o_sel[1] != 2) begin errors++;
        $display("FAIL bp_resume %0d got rd %0b sel %0d exp 1 2", k, o_rd[1], o_sel[1]); end
    end
    step(); checks++;
    if (o_busy[1] !== 1'b0 || o_rd[1] !== 1'b0) begin errors++;
      $display("FAIL bp_end got busy %0b rd %0b exp 0 0", o_busy[1], o_rd[1]); end
    checks++;
    if (qcnt[1][2] != 4) begin errors++; $display("FAIL bp_total_reads got %0d exp 4", 8 - qcnt[1][2]); end
  endtask

  task automatic test_abort();
    do_reset();
    qcnt[2][1] = 6; drive_empty();
    step();
    step(); checks++;
    if (o_rd[2] !== 1'b1) begin errors++; $display("FAIL abort_first_read got %0b exp 1", o_rd[2]); end
    sched_en = 1'b0;
    step(); checks++;
    if (o_rd[2] !== 1'b0 || o_ov[2] !== 1'b1 || o_src[2] != 1) begin errors++;
      $display("FAIL abort_drop got rd %0b ov %0b src %0d exp 0 1 1", o_rd[2], o_ov[2], o_src[2]); end
    for (int k = 0; k < 3; k++) begin
      step(); checks++;
      if (o_busy[2] !== 1'b0 || o_rd[2] !== 1'b0) begin errors++;
        $display("FAIL abort_idle %0d got busy %0b rd %0b exp 0 0", k, o_busy[2], o_rd[2]); end
    end
    checks++;
    if (qcnt[2][1] != 5) begin errors++; $display("FAIL abort_words_left got %0d exp 5", qcnt[2][1]); end
    sched_en = 1'b1;
  endtask

  task automatic test_parallel();
    logic [13:0] rdh [P];
    int first [P], reads [P], badsel [P];
    do_reset();
    for (int i = 0; i < P; i++) begin
      qcnt[i][3-i] = 5; first[i] = -1; reads[i] = 0; badsel[i] = 0;
    end
    drive_empty();
    for (int k = 0; k < 14; k++) begin
      step();
      for (int i = 0; i < P; i++) begin
        rdh[i][k] = o_rd[i];
        if (o_rd[i]) begin
          reads[i]++;
          if (first[i] < 0) first[i] = k;
          if (o_sel[i] != 3-i) badsel[i]++;
        end
      end
    end
    for (int i = 0; i < P; i++) begin
      checks++;
      if (first[i] != 1) begin errors++; $display("FAIL par_first_rd[%0d] got %0d exp 1", i, first[i]); end
      checks++;
      if (badsel[i] != 0) begin errors++; $display("FAIL par_rd_sel[%0d] bad %0d exp 0", i, badsel[i]); end
      checks++;
      if (reads[i] != 5) begin errors++; $display("FAIL par_reads[%0d] got %0d exp 5", i, reads[i]); end
      checks++;
      if (rdh[i][7:1] !== 7'b0101111) begin errors++;
        $display("FAIL par_pattern[%0d] got %b exp 0101111", i, rdh[i][7:1]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sched_en = ($urandom_range(0, 9) != 0);
      tx_ready = P'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0)
        qcnt[$urandom_range(0, P-1)][$urandom_range(0, P-1)] += $urandom_range(1, 6);
      drive_empty();
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < P; i++) for (int j = 0; j < P; j++) qcnt[i][j] = 0;
    test_reset();
    test_single_queue();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_parallel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
